gmii_tx_arbiter: RTL

//  Shares the single GMII transmit port (gmii_tx_en/gmii_txd, feeding the RGMII DDR output stage) between two frame sources.

---
 rtl/gmii_tx_pkg.sv | 19 +
 rtl/gmii_rr_arb2.sv | 26 ++
 rtl/gmii_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII TX arbiter.
// The PREAMBLE state exists only when GMII_TX_PREAMBLE_EN is defined.
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef GMII_TX_PREAMBLE_EN
        ST_PREAMBLE,
`endif
        ST_PAYLOAD,
        ST_DRAIN,
        ST_IFG
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

endpackage

// File: rtl/gmii_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last source served.
// A tie goes to the source the pointer does not name.
module gmii_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt
);

    logic ptr;

    always_comb begin
        gnt = 1'b0;
        if (req0 && req1) gnt = ~ptr;
        else              gnt = req1 & ~req0;
    end

    // Pointer resets to 1 so source 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= 1'b1;
        else if (take) ptr <= gnt;
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII TX port between two byte-stream frame sources, one whole frame per grant.
// Define GMII_TX_PREAMBLE_EN to generate 7x 55 + D5 ahead of every frame in hardware.
module gmii_tx_arbiter
    import gmii_tx_pkg::*;
#(
    parameter int IFG_BYTES       = 12,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       stat_underrun,
    output logic       stat_oversize
);

    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 2);
    localparam int AUX_W = $clog2(IFG_BYTES + PREAMBLE_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_FRAME_BYTES);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [AUX_W-1:0] IFG_LAST = AUX_W'(IFG_BYTES - 2);

    state_t           state, state_next;
    logic             gnt_q, arb_gnt, arb_take;
    logic [CNT_W-1:0] cnt;
    logic [AUX_W-1:0] aux;
    logic             src_valid, src_last, src_ready, accept;
    logic [7:0]       src_data;
    logic             tx_en_d, underrun_d, oversize_d;
    logic [7:0]       txd_d;
    logic             cnt_clr, cnt_inc, aux_clr, aux_inc;

    gmii_rr_arb2 u_arb (
        .clk  (gmii_tx_clk),
        .rst  (rst),
        .req0 (s0_valid),
        .req1 (s1_valid),
        .take (arb_take),
        .gnt  (arb_gnt)
    );

    // A byte moves when valid & ready at the clock edge; ready depends only on state and grant.
    assign src_valid = gnt_q ? s1_valid : s0_valid;
    assign src_data  = gnt_q ? s1_data  : s0_data;
    assign src_last  = gnt_q ? s1_last  : s0_last;
    assign s0_ready  = src_ready & ~gnt_q;
    assign s1_ready  = src_ready &  gnt_q;
    assign accept    = src_valid & src_ready;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        src_ready  = 1'b0;
        arb_take   = 1'b0;
        tx_en_d    = 1'b0;
        txd_d      = 8'h00;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        aux_clr    = 1'b0;
        aux_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    arb_take = 1'b1;
                    cnt_clr  = 1'b1;
                    aux_clr  = 1'b1;
`ifdef GMII_TX_PREAMBLE_EN
                    state_next = ST_PREAMBLE;
`else
                    state_next = ST_PAYLOAD;
`endif
                end
            end
`ifdef GMII_TX_PREAMBLE_EN
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                aux_inc = 1'b1;
                txd_d   = PREAMBLE_BYTE;
                if (aux == AUX_W'(PREAMBLE_LEN)) begin
                    txd_d      = SFD_BYTE;
                    cnt_clr    = 1'b1;
                    state_next = ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                src_ready = 1'b1;
                aux_clr   = 1'b1;
                if (!src_valid) begin
                    underrun_d = 1'b1;
                    state_next = ST_DRAIN;
                end else if (cnt == CNT_MAX) begin
                    // Byte MAX+1 is swallowed; the rest of the frame is drained silently.
                    oversize_d = 1'b1;
                    state_next = src_last ? ST_IFG : ST_DRAIN;
                end else begin
                    tx_en_d = 1'b1;
                    txd_d   = src_data;
                    cnt_inc = 1'b1;
                    if (src_last) state_next = ST_IFG;
                end
            end
            ST_DRAIN: begin
                src_ready = 1'b1;
                aux_clr   = 1'b1;
                if (accept && src_last) state_next = ST_IFG;
            end
            ST_IFG: begin
                // IFG_BYTES-1 cycles here plus the IDLE grant cycle give IFG_BYTES low cycles.
                aux_inc = 1'b1;
                if (aux == IFG_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            gnt_q         <= 1'b0;
            cnt           <= '0;
            aux           <= '0;
            gmii_tx_en    <= 1'b0;
            gmii_txd      <= 8'h00;
            stat_underrun <= 1'b0;
            stat_oversize <= 1'b0;
        end else begin
            if (arb_take) gnt_q <= arb_gnt;
            if (cnt_clr)                       cnt <= '0;
            else if (cnt_inc && cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
            if (aux_clr)      aux <= '0;
            else if (aux_inc) aux <= aux + AUX_W'(1);
            gmii_tx_en    <= tx_en_d;
            gmii_txd      <= txd_d;
            stat_underrun <= underrun_d;
            stat_oversize <= oversize_d;
        end
    end

endmodule
